regfile_write_arbiter: RTL

- Shares the single write port (RegWrite/Writereg/Writedata) of the 32x32 register file between two producers.
- Producer 0 is the pipeline writeback stage: single cycle, default priority.
- Producer 1 is a multicycle unit (mult/div) with a valid/ready handshake, buffered in a small FIFO.
- Anti-starvation and drain sequencing live here; registered outputs feed the regfile, which commits on negedge clk.

---
 rtl/regfile_write_arbiter_pkg.sv | 13 +
 rtl/regfile_wr_fifo.sv | 42 ++++
 rtl/regfile_write_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg: shared widths, FSM encoding and FIFO entry type for the regfile write arbiter
package regfile_write_arbiter_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_STARVE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  typedef struct packed {
    logic [REG_W-1:0] rg;
    logic [DATA_W-1:0] data;
  } wr_entry_t;
endpackage

// File: rtl/regfile_wr_fifo.sv
// regfile_wr_fifo: circular FIFO of pending multicycle {reg,data} writes
module regfile_wr_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      i_push,
  input  logic      i_pop,
  input  wr_entry_t i_data,
  output logic      o_full,
  output logic      o_empty,
  output logic [AW:0] o_count,
  output wr_entry_t o_head
);
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  wr_entry_t r_mem [DEPTH];
  logic w_push, w_pop;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_head = r_mem[r_rptr];
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the regfile write port between writeback and a buffered multicycle unit
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        mc_valid,
  output logic        mc_ready,
  input  logic [4:0]  mc_reg,
  input  logic [31:0] mc_data,
  input  logic        drain_req,
  output logic        drain_done,
  output logic        mc_pending,
  output logic        RegWrite,
  output logic [4:0]  Writereg,
  output logic [31:0] Writedata
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  logic [1:0] r_state, w_state_nxt;
  logic [WW-1:0] r_wait, w_wait_nxt;
  logic r_regwrite, r_drain_done;
  logic [4:0] r_writereg;
  logic [31:0] r_writedata;
  logic w_full, w_empty, w_push, w_pop, w_wb_win, w_done;
  logic [AW:0] w_count, w_count_nxt;
  wr_entry_t w_head;
  regfile_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_data('{rg: mc_reg, data: mc_data}),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(w_count),
    .o_head(w_head)
  );
  assign mc_ready = reset_n && r_state != ST_DRAIN && !w_full;
  assign wb_stall = !reset_n || r_state == ST_STARVE || r_state == ST_DRAIN || (r_wait == WAIT_MAX && !w_empty);
  // r0 results are acknowledged but never reach the FIFO or the port
  assign w_push = mc_valid && mc_ready && mc_reg != REG_ZERO;
  assign w_wb_win = wb_valid && !wb_stall && wb_reg != REG_ZERO;
  assign w_pop = reset_n && !w_wb_win && !w_empty;
  assign w_count_nxt = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_done = r_state == ST_DRAIN && w_count_nxt == '0;
  always_comb begin
    w_wait_nxt = (w_pop || w_count_nxt == '0) ? '0 :
                 (w_wb_win && !w_empty && r_wait != WAIT_MAX) ? r_wait + 1'b1 : r_wait;
    // STARVE is entered one cycle ahead so the head wins exactly when the counter saturates
    w_state_nxt = (r_state == ST_DRAIN) ? (w_done ? ST_NORMAL : ST_DRAIN) :
                  drain_req ? ST_DRAIN :
                  (r_state == ST_NORMAL && w_wait_nxt == WAIT_MAX && w_count_nxt != '0) ? ST_STARVE : ST_NORMAL;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_NORMAL;
      r_wait <= '0;
      r_regwrite <= 1'b0;
      r_writereg <= '0;
      r_writedata <= '0;
      r_drain_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait <= w_wait_nxt;
      r_drain_done <= w_done;
      r_regwrite <= w_wb_win || w_pop;
      if (w_wb_win) begin
        r_writereg <= wb_reg;
        r_writedata <= wb_data;
      end else if (w_pop) begin
        r_writereg <= w_head.rg;
        r_writedata <= w_head.data;
      end
    end
  end
  assign RegWrite = r_regwrite;
  assign Writereg = r_writereg;
  assign Writedata = r_writedata;
  assign drain_done = r_drain_done;
  assign mc_pending = !w_empty;
endmodule
